// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// The helpers take max-width vectors so callers of any legal size can use them.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_RD     = 4;
  localparam int MAX_DEPTH  = 1 << MAX_ADDR_W;

  function automatic logic [MAX_ADDR_W:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [MAX_ADDR_W:0] cnt;
    cnt = '0;
    for (int k = 0; k < MAX_DEPTH; k++) cnt += (MAX_ADDR_W+1)'(v[k]);
    return cnt;
  endfunction

  // Callers truncate the result to their own field width w.
  function automatic logic [MAX_ADDR_W-1:0] rf_field_addr(
    input logic [MAX_RD*MAX_ADDR_W-1:0] bus, input int i, input int w);
    return MAX_ADDR_W'(bus >> (i*w));
  endfunction

  function automatic logic [MAX_DATA_W-1:0] rf_field_data(
    input logic [MAX_RD*MAX_DATA_W-1:0] bus, input int i, input int w);
    return MAX_DATA_W'(bus >> (i*w));
  endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write bits with issue/writeback/flush priority and a
// registered count of busy registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]       busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]     busy_nxt;
  logic [MAX_DEPTH-1:0] busy_ext;

  // Clear, then set (new producer supersedes the retiring one), then flush.
  always_comb begin
    busy_nxt = busy;
    if (wen) busy_nxt[waddr] = 1'b0;
    if (iss_valid && !(ZERO_REG != 0 && iss_addr == '0)) busy_nxt[iss_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    busy_ext = '0;
    busy_ext[DEPTH-1:0] = busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= (ADDR_W+1)'(popcount(busy_ext));
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-port bypass, pending-write scoreboard
// and a raw debug read port.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0]     mem;
  logic [DEPTH-1:0]                 busy;
  logic [MAX_RD*MAX_ADDR_W-1:0]     raddr_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem <= '0;
    else if (wen && !(ZERO_REG != 0 && waddr == '0))
      mem[waddr] <= wdata;
  end

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  always_comb begin
    raddr_ext = '0;
    raddr_ext[NUM_RD*ADDR_W-1:0] = raddr;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              zr;
    assign ra  = ADDR_W'(rf_field_addr(raddr_ext, i, ADDR_W));
    assign hit = (BYPASS != 0) && wen && (waddr == ra);
    assign zr  = (ZERO_REG != 0) && (ra == '0);
    // Zero register wins over bypass; a retiring write hides the busy bit.
    assign rdata[i*DATA_W +: DATA_W] = zr ? '0 : (hit ? wdata : mem[ra]);
    assign rbusy[i] = !zr && busy[ra] && !hit;
  end

  assign dbg_data = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule
